// File: rtl/fme_pkg.sv
// Shared types, candidate geometry and saturating arithmetic for fractional
// motion estimation refinement.
package fme_pkg;

  localparam int NUM_CAND = 9;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    CMP,
    WAIT,
    UPD,
    DONE
  } state_e;

  typedef enum logic {
    HALF,
    QUARTER
  } stage_e;

  // Unit offsets of the 3x3 search pattern; index 0 is the centre.
  localparam int DX_TAB [NUM_CAND] = '{0, -1, 0, 1, -1, 1, -1, 0, 1};
  localparam int DY_TAB [NUM_CAND] = '{0, -1, -1, -1, 0, 0, 1, 1, 1};

  function automatic int cand_dx(input logic [3:0] idx);
    return (idx < 4'(NUM_CAND)) ? DX_TAB[idx] : 0;
  endfunction

  function automatic int cand_dy(input logic [3:0] idx);
    return (idx < 4'(NUM_CAND)) ? DY_TAB[idx] : 0;
  endfunction

  // Adds off to base and clamps to the signed range of a width-bit value.
  function automatic int sat_add(input int base, input int off, input int width);
    int sum;
    int hi;
    int lo;
    sum = base + off;
    hi  = (1 << (width - 1)) - 1;
    lo  = -hi - 1;
    if (sum > hi) return hi;
    if (sum < lo) return lo;
    return sum;
  endfunction

endpackage

// File: rtl/fme_search_ctrl_cmp.sv
// 9-way minimum selector: registers the index of the lowest distortion
// (lowest index wins ties) one cycle after en_i.
module fme_search_ctrl_cmp
  import fme_pkg::*;
#(
  parameter int DIST_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic [DIST_W-1:0] dist_i [NUM_CAND],
  output logic [3:0]        best_idx_o
);

  logic [3:0]        best_idx_d;
  logic [3:0]        best_idx_q;
  logic [DIST_W-1:0] best_dist;

  // Strict less-than keeps the earliest index on equal distortions.
  always_comb begin
    best_idx_d = '0;
    best_dist  = dist_i[0];
    for (int i = 1; i < NUM_CAND; i++) begin
      if (dist_i[i] < best_dist) begin
        best_idx_d = 4'(i);
        best_dist  = dist_i[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      best_idx_q <= '0;
    end else if (en_i) begin
      best_idx_q <= best_idx_d;
    end
  end

  assign best_idx_o = best_idx_q;

endmodule

// File: rtl/fme_search_ctrl.sv
// Two-stage (half-pel then quarter-pel) fractional ME refinement sequencer.
// Request handshake: a candidate transfers on a cycle where req_valid && req_ready.
module fme_search_ctrl
  import fme_pkg::*;
#(
  parameter int MV_W   = 12,
  parameter int DIST_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [MV_W-1:0]   imv_x,
  input  logic [MV_W-1:0]   imv_y,
  output logic              busy,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [3:0]        req_idx,
  output logic [MV_W-1:0]   req_mv_x,
  output logic [MV_W-1:0]   req_mv_y,
  input  logic              rsp_valid,
  input  logic [3:0]        rsp_idx,
  input  logic [DIST_W-1:0] rsp_dist,
  output logic              done,
  output logic [MV_W-1:0]   mv_x,
  output logic [MV_W-1:0]   mv_y,
  output logic [DIST_W-1:0] best_cost,
  output logic [2:0]        dbg_state
);

  state_e              state_q, state_d;
  stage_e              stage_q, stage_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [NUM_CAND-1:0] mask_q, mask_d;
  logic [MV_W-1:0]     cx_q, cx_d, cy_q, cy_d;
  logic [MV_W-1:0]     mv_x_q, mv_x_d, mv_y_q, mv_y_d;
  logic [DIST_W-1:0]   cost_q, cost_d;
  logic [DIST_W-1:0]   dist_q [NUM_CAND];
  logic [3:0]          best_idx;
  logic                rsp_hit;
  int                  step;
  logic [MV_W-1:0]     upd_x, upd_y;

  assign rsp_hit   = (state_q == RUN) && rsp_valid && (rsp_idx < 4'(NUM_CAND));
  assign req_valid = (state_q == RUN) && (cnt_q < 4'(NUM_CAND));
  assign req_idx   = cnt_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign mv_x      = mv_x_q;
  assign mv_y      = mv_y_q;
  assign best_cost = cost_q;
  assign dbg_state = state_q;

  // Candidate and recentred MVs share the same clamp to the signed MV range.
  always_comb begin
    step     = (stage_q == HALF) ? 2 : 1;
    req_mv_x = MV_W'(sat_add(int'($signed(cx_q)), cand_dx(cnt_q) * step, MV_W));
    req_mv_y = MV_W'(sat_add(int'($signed(cy_q)), cand_dy(cnt_q) * step, MV_W));
    upd_x    = MV_W'(sat_add(int'($signed(cx_q)), cand_dx(best_idx) * step, MV_W));
    upd_y    = MV_W'(sat_add(int'($signed(cy_q)), cand_dy(best_idx) * step, MV_W));
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    mv_x_d  = mv_x_q;
    mv_y_d  = mv_y_q;
    cost_d  = cost_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cx_d    = imv_x;
          cy_d    = imv_y;
          stage_d = HALF;
          cnt_d   = '0;
          mask_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (req_valid && req_ready) cnt_d = cnt_q + 4'd1;
        if (rsp_hit) mask_d[rsp_idx] = 1'b1;
        // The response completing the mask is written this same edge.
        if (cnt_q == 4'(NUM_CAND) && mask_d == '1) state_d = CMP;
      end
      CMP:  state_d = WAIT;
      WAIT: state_d = UPD;
      UPD: begin
        cx_d = upd_x;
        cy_d = upd_y;
        if (stage_q == HALF) begin
          stage_d = QUARTER;
          cnt_d   = '0;
          mask_d  = '0;
          state_d = RUN;
        end else begin
          mv_x_d  = upd_x;
          mv_y_d  = upd_y;
          cost_d  = dist_q[best_idx];
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      stage_q <= HALF;
      cnt_q   <= '0;
      mask_q  <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      mv_x_q  <= '0;
      mv_y_q  <= '0;
      cost_q  <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      mv_x_q  <= mv_x_d;
      mv_y_q  <= mv_y_d;
      cost_q  <= cost_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CAND; i++) dist_q[i] <= '0;
    end else if (rsp_hit) begin
      dist_q[rsp_idx] <= rsp_dist;
    end
  end

  fme_search_ctrl_cmp #(
    .DIST_W(DIST_W)
  ) u_cmp (
    .clk       (clk),
    .rst       (rst),
    .en_i      (state_q == CMP),
    .dist_i    (dist_q),
    .best_idx_o(best_idx)
  );

endmodule
